// File: rtl/imm_encoder_pkg.sv
// Shared types and constants for the immediate-operand encoder.
// Search walks even rotations of a 32-bit word looking for an 8-bit window.
package imm_encoder_pkg;

  localparam int WORD_W    = 32;
  localparam int IMM_W     = 8;
  localparam int ROT_STEPS = 16;
  localparam int ROT_W     = $clog2(ROT_STEPS);
  localparam int K_W       = ROT_W + 1;
  localparam int OPND_W    = ROT_W + IMM_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Rotate left modulo the word width; amt=0 returns w unchanged.
  function automatic logic [WORD_W-1:0] rol32(input logic [WORD_W-1:0] w,
                                              input logic [K_W-1:0]    amt);
    logic [2*WORD_W-1:0] dbl;
    dbl = {w, w} << amt;
    return dbl[2*WORD_W-1:WORD_W];
  endfunction

endpackage

// File: rtl/imm_encoder_rot_check.sv
// Tests one rotation: rotate w left by 2*r and check that only the low byte is populated.
module imm_rot_check
  import imm_encoder_pkg::*;
(
  input  logic [WORD_W-1:0] w_i,
  input  logic [ROT_W-1:0]  r_i,
  output logic              hit_o,
  output logic [IMM_W-1:0]  imm8_o
);

  logic [WORD_W-1:0] rot;

  assign rot    = rol32(w_i, {r_i, 1'b0});
  assign hit_o  = (rot[WORD_W-1:IMM_W] == '0);
  assign imm8_o = rot[IMM_W-1:0];

endmodule

// File: rtl/imm_encoder.sv
// Sequential immediate encoder: tries one rotation per cycle, direct form first,
// then (optionally) the inverted form, and reports the first encoding found.
module imm_encoder
  import imm_encoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] value,
  input  logic              allow_inv,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic              inverted,
  output logic [OPND_W-1:0] shift_operand
);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   value_q, value_d;
  logic                allow_inv_q, allow_inv_d;
  logic [K_W-1:0]      k_q, k_d;
  logic                valid_q, valid_d;
  logic                inverted_q, inverted_d;
  logic [OPND_W-1:0]   operand_q, operand_d;

  logic [WORD_W-1:0]   w;
  logic                hit;
  logic [IMM_W-1:0]    imm8;
  logic                last_attempt;

  // Attempts 0..15 test value, 16..31 test ~value; k[3:0] is the rotate field.
  assign w = k_q[K_W-1] ? ~value_q : value_q;

  imm_rot_check u_rot_check (
    .w_i    (w),
    .r_i    (k_q[ROT_W-1:0]),
    .hit_o  (hit),
    .imm8_o (imm8)
  );

  assign last_attempt = allow_inv_q ? (k_q == K_W'(2*ROT_STEPS-1))
                                    : (k_q == K_W'(ROT_STEPS-1));

  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    allow_inv_d = allow_inv_q;
    k_d         = k_q;
    valid_d     = valid_q;
    inverted_d  = inverted_q;
    operand_d   = operand_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          value_d     = value;
          allow_inv_d = allow_inv;
          k_d         = '0;
          state_d     = SEARCH;
        end
      end
      SEARCH: begin
        if (hit) begin
          valid_d    = 1'b1;
          inverted_d = k_q[K_W-1];
          operand_d  = {k_q[ROT_W-1:0], imm8};
          state_d    = DONE;
        end else if (last_attempt) begin
          valid_d    = 1'b0;
          inverted_d = 1'b0;
          operand_d  = '0;
          state_d    = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      value_q     <= '0;
      allow_inv_q <= 1'b0;
      k_q         <= '0;
      valid_q     <= 1'b0;
      inverted_q  <= 1'b0;
      operand_q   <= '0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      allow_inv_q <= allow_inv_d;
      k_q         <= k_d;
      valid_q     <= valid_d;
      inverted_q  <= inverted_d;
      operand_q   <= operand_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign valid         = valid_q;
  assign inverted      = inverted_q;
  assign shift_operand = operand_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed vector table, reset-abort sequence,
// and randomized requests against a bit-level window model.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] value;
  logic        allow_inv;
  logic        busy;
  logic        done;
  logic        valid;
  logic        inverted;
  logic [11:0] shift_operand;

  always #5 clk = ~clk;

  imm_encoder dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .value         (value),
    .allow_inv     (allow_inv),
    .busy          (busy),
    .done          (done),
    .valid         (valid),
    .inverted      (inverted),
    .shift_operand (shift_operand)
  );

  typedef struct {
    logic [31:0] value;
    logic        allow;
    int          busy_at;
    int          lat;
    logic        vld;
    logic        inv;
    logic [11:0] op;
  } vec_t;

  vec_t        tbl[7];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // imm8 ROR 2*rot: imm8 bit i lands at bit (i - 2*rot) mod 32.
  function automatic logic [31:0] decode(input logic [11:0] op);
    logic [31:0] d;
    int          s;
    d = '0;
    s = 2 * int'(op[11:8]);
    for (int i = 0; i < 8; i++) d[(i - s + 32) % 32] = op[i];
    return d;
  endfunction

  // Reference: first k whose 8-bit window (after decode rules) covers every set bit.
  function automatic void model(input logic [31:0] v, input logic al, output vec_t e);
    int          last;
    int          s;
    logic [31:0] w;
    logic        fits;
    logic        in_win;
    logic        found;
    logic [7:0]  imm;
    last    = al ? 31 : 15;
    e.value = v;
    e.allow = al;
    e.busy_at = 0;
    e.vld   = 1'b0;
    e.inv   = 1'b0;
    e.op    = '0;
    e.lat   = last + 2;
    found   = 1'b0;
    for (int k = 0; k <= last; k++) begin
      if (!found) begin
        w = (k < 16) ? v : ~v;
        s = 2 * (k % 16);
        fits = 1'b1;
        for (int j = 0; j < 32; j++) begin
          if (w[j]) begin
            in_win = 1'b0;
            for (int i = 0; i < 8; i++) if ((i - s + 32) % 32 == j) in_win = 1'b1;
            if (!in_win) fits = 1'b0;
          end
        end
        if (fits) begin
          for (int i = 0; i < 8; i++) imm[i] = w[(i - s + 32) % 32];
          found = 1'b1;
          e.vld = 1'b1;
          e.inv = (k >= 16);
          e.op  = {4'(k % 16), imm};
          e.lat = k + 2;
        end
      end
    end
  endfunction

  // Drives one request from cycle 0, optionally pokes start while busy, then checks
  // latency, results, the single-cycle done pulse, and that start in DONE is ignored.
  task automatic run_req(input vec_t t, input string tag);
    int          lat;
    logic [31:0] w;
    value     = t.value;
    allow_inv = t.allow;
    start     = 1'b1;
    exp_q.push_back(t.value);
    @(posedge clk); #1;
    start     = 1'b0;
    value     = $urandom;
    allow_inv = 1'($urandom);
    lat = 1;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && lat < 40) begin
      start = (lat == t.busy_at);
      if (lat == t.busy_at) value = 32'h0000_00FF;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(t.lat));
    check({tag, "_valid"}, 32'(valid), 32'(t.vld));
    check({tag, "_inverted"}, 32'(inverted), 32'(t.inv));
    check({tag, "_operand"}, 32'(shift_operand), 32'(t.op));
    w = exp_q.pop_front();
    if (valid === 1'b1)
      check({tag, "_sb_decode"}, decode(shift_operand), inverted ? ~w : w);
    start = 1'b1;
    value = 32'h0000_0000;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
    check({tag, "_hold_op"}, 32'(shift_operand), 32'(t.op));
  endtask

  initial begin
    vec_t        e;
    logic        saw;
    logic [31:0] v;
    logic [7:0]  imm;
    int          rr;
    int          mode;

    tbl[0] = '{32'h0000_00FF, 1'b0, 0,  2, 1'b1, 1'b0, 12'h0FF};
    tbl[1] = '{32'hFF00_0000, 1'b0, 0,  6, 1'b1, 1'b0, 12'h4FF};
    tbl[2] = '{32'h0000_03FC, 1'b0, 0, 17, 1'b1, 1'b0, 12'hFFF};
    tbl[3] = '{32'hFFFF_FF00, 1'b0, 0, 17, 1'b0, 1'b0, 12'h000};
    tbl[4] = '{32'h0000_0000, 1'b0, 0,  2, 1'b1, 1'b0, 12'h000};
    tbl[5] = '{32'h0000_0102, 1'b1, 3, 33, 1'b0, 1'b0, 12'h000};
    tbl[6] = '{32'hFFFF_FF00, 1'b1, 0, 18, 1'b1, 1'b1, 12'h0FF};

    rst = 1'b1; start = 1'b0; value = '0; allow_inv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_inverted", 32'(inverted), 32'd0);
    check("rst_operand", 32'(shift_operand), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_req(tbl[i], $sformatf("tbl%0d", i));

    // Abort a search in cycle 5; outputs from the previous inverted hit must clear at once.
    value = 32'h0000_03FC; allow_inv = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_inverted", 32'(inverted), 32'd0);
    check("abort_operand", 32'(shift_operand), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      saw = saw | done | busy;
    end
    check("abort_no_done", 32'(saw), 32'd0);
    run_req(tbl[2], "after_abort");

    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 3);
      imm  = 8'($urandom);
      rr   = $urandom_range(0, 15);
      case (mode)
        0:       v = decode({4'(rr), imm});
        1:       v = ~decode({4'(rr), imm});
        2:       v = $urandom;
        default: v = 32'(imm) << (2 * rr + 1);
      endcase
      model(v, 1'($urandom), e);
      e.busy_at = $urandom_range(0, 4);
      run_req(e, $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
